instruction_c_align: RTL and testbench

INSTRUCTION_C_ALIGN -- requirements
Module: instruction_c_align

---
 rtl/instruction_c_align.sv | 108 ++++++++++
 tb/tb_instruction_c_align.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instruction_c_align.sv
// Fetch/align front end: turns a stream of 32-bit fetch words into 16/32-bit
// (RVC-style) instructions through a 3-halfword buffer with flush redirect.
module instruction_c_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  input  logic        iFLUSH,
  input  logic [31:0] iFLUSH_PC,
  output logic        oFETCH_REQ,
  output logic [31:0] oFETCH_ADDR,
  input  logic        iFETCH_VALID,
  input  logic [31:0] iFETCH_DATA,
  output logic        oIR_VALID,
  input  logic        iIR_READY,
  output logic [31:0] oIR,
  output logic [31:0] oIR_PC,
  output logic        oIR_IS_C
);

  localparam int DEPTH = 3;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fetchState_e;

  fetchState_e            state, stateNext;
  logic [DEPTH-1:0][15:0] hw, hwNext;
  logic [1:0]             count, countNext;
  logic [31:0]            pc, pcNext;
  logic [31:0]            fetchAddr, fetchAddrNext;
  logic                   skip, skipNext;

  logic       hw0IsC;
  logic       fire, append, reqGo;
  logic [1:0] consumed, rem, appended;

  assign hw0IsC = (hw[0][1:0] != 2'b11);

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state     <= F_IDLE;
      hw        <= '0;
      count     <= 2'd0;
      pc        <= RESET_PC;
      fetchAddr <= {RESET_PC[31:2], 2'b00};
      skip      <= RESET_PC[1];
    end else begin
      state     <= stateNext;
      hw        <= hwNext;
      count     <= countNext;
      pc        <= pcNext;
      fetchAddr <= fetchAddrNext;
      skip      <= skipNext;
    end
  end

  always_comb begin
    oIR_VALID = !iFLUSH && (((count >= 2'd1) && hw0IsC) || ((count >= 2'd2) && !hw0IsC));
    fire      = oIR_VALID && iIR_READY;
    // Request gated by reset so nothing leaves the block while iRSTN is low.
    reqGo     = iRSTN && !iFLUSH && (state == F_IDLE) && (count <= 2'd1);
    append    = !iFLUSH && (state == F_WAIT) && iFETCH_VALID;
    consumed  = fire ? (hw0IsC ? 2'd1 : 2'd2) : 2'd0;
    rem       = count - consumed;
    appended  = append ? (skip ? 2'd1 : 2'd2) : 2'd0;

    // Shift out consumed halfwords first, then append behind the survivors.
    hwNext = hw;
    for (int i = 0; i < DEPTH; i++) begin
      if (i + int'(consumed) < DEPTH) hwNext[i] = hw[i + int'(consumed)];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (append && (i == int'(rem)))
        hwNext[i] = skip ? iFETCH_DATA[31:16] : iFETCH_DATA[15:0];
      if (append && !skip && (i == int'(rem) + 1))
        hwNext[i] = iFETCH_DATA[31:16];
    end

    countNext     = rem + appended;
    pcNext        = pc + (fire ? (hw0IsC ? 32'd2 : 32'd4) : 32'd0);
    fetchAddrNext = reqGo ? fetchAddr + 32'd4 : fetchAddr;
    skipNext      = append ? 1'b0 : skip;

    stateNext = state;
    case (state)
      F_IDLE:  if (reqGo)        stateNext = F_WAIT;
      F_WAIT:  if (iFETCH_VALID) stateNext = F_IDLE;
      F_DROP:  if (iFETCH_VALID) stateNext = F_IDLE;
      default:                   stateNext = F_IDLE;
    endcase

    // A response still in flight at flush time must be swallowed in F_DROP.
    if (iFLUSH) begin
      countNext     = 2'd0;
      pcNext        = iFLUSH_PC;
      fetchAddrNext = {iFLUSH_PC[31:2], 2'b00};
      skipNext      = iFLUSH_PC[1];
      stateNext     = ((state != F_IDLE) && !iFETCH_VALID) ? F_DROP : F_IDLE;
    end
  end

  assign oFETCH_REQ  = reqGo;
  assign oFETCH_ADDR = {fetchAddr[31:2], 2'b00};
  assign oIR_PC      = pc;
  assign oIR_IS_C    = (count != 2'd0) && hw0IsC;
  assign oIR         = (count == 2'd0) ? 32'h0 :
                       hw0IsC ? {16'h0, hw[0]} : {hw[1], hw[0]};

endmodule

// File: tb/tb_instruction_c_align.sv
// Directed bench for instruction_c_align: inputs driven on the falling edge,
// outputs sampled 1 time unit later, expected values hand-computed.
module tb_instruction_c_align;

  logic        iCLK, iRSTN, iFLUSH;
  logic [31:0] iFLUSH_PC;
  logic        oFETCH_REQ;
  logic [31:0] oFETCH_ADDR;
  logic        iFETCH_VALID;
  logic [31:0] iFETCH_DATA;
  logic        oIR_VALID, iIR_READY;
  logic [31:0] oIR, oIR_PC;
  logic        oIR_IS_C;

  int checks = 0;
  int failures = 0;

  instruction_c_align #(.RESET_PC(32'h0000_0000)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iFLUSH(iFLUSH), .iFLUSH_PC(iFLUSH_PC),
    .oFETCH_REQ(oFETCH_REQ), .oFETCH_ADDR(oFETCH_ADDR),
    .iFETCH_VALID(iFETCH_VALID), .iFETCH_DATA(iFETCH_DATA),
    .oIR_VALID(oIR_VALID), .iIR_READY(iIR_READY),
    .oIR(oIR), .oIR_PC(oIR_PC), .oIR_IS_C(oIR_IS_C)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge iCLK);
  endtask

  initial begin
    iRSTN = 1'b0; iFLUSH = 1'b0; iFLUSH_PC = '0;
    iFETCH_VALID = 1'b0; iFETCH_DATA = '0; iIR_READY = 1'b0;

    repeat (2) step(); #1;
    chk("rst_req", oFETCH_REQ, 0);  chk("rst_irv", oIR_VALID, 0);
    chk("rst_ir", oIR, 0);          chk("rst_isc", oIR_IS_C, 0);
    chk("rst_pc", oIR_PC, 0);       chk("rst_addr", oFETCH_ADDR, 0);

    // first fetch after release, two compressed halfwords
    step(); iRSTN = 1'b1; #1;
    chk("req0", oFETCH_REQ, 1);     chk("addr0", oFETCH_ADDR, 32'h0);
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'h4501_4505; #1;
    chk("wait_req", oFETCH_REQ, 0); chk("wait_irv", oIR_VALID, 0);
    step(); iFETCH_VALID = 1'b0; iIR_READY = 1'b1; #1;
    chk("c0_ir", oIR, 32'h4505);    chk("c0_isc", oIR_IS_C, 1);
    chk("c0_pc", oIR_PC, 32'h0);    chk("c0_noreq", oFETCH_REQ, 0);
    step(); #1;
    chk("c1_ir", oIR, 32'h4501);    chk("c1_pc", oIR_PC, 32'h2);
    chk("c1_req", oFETCH_REQ, 1);   chk("c1_addr", oFETCH_ADDR, 32'h4);

    // misaligned 32-bit instruction spanning two words
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'h0093_4505; iIR_READY = 1'b0; #1;
    chk("m_empty", oIR_VALID, 0);
    step(); iFETCH_VALID = 1'b0; iIR_READY = 1'b1; #1;
    chk("m0_ir", oIR, 32'h4505);    chk("m0_pc", oIR_PC, 32'h4);
    step(); #1;
    chk("m_half", oIR_VALID, 0);    chk("m_req", oFETCH_REQ, 1);
    chk("m_addr", oFETCH_ADDR, 32'h8);
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'h0000_0513; iIR_READY = 1'b0; #1;
    chk("m_wait", oIR_VALID, 0);

    // stall: downstream not ready for 5 cycles, buffer full
    for (int i = 0; i < 5; i++) begin
      step(); iFETCH_VALID = 1'b0; #1;
      chk("st_irv", oIR_VALID, 1);  chk("st_ir", oIR, 32'h0513_0093);
      chk("st_isc", oIR_IS_C, 0);   chk("st_pc", oIR_PC, 32'h6);
      chk("st_noreq", oFETCH_REQ, 0);
    end
    step(); iIR_READY = 1'b1; #1;
    chk("st_hold", oIR, 32'h0513_0093);
    step(); iIR_READY = 1'b0; #1;
    chk("z_ir", oIR, 32'h0);        chk("z_isc", oIR_IS_C, 1);
    chk("z_irv", oIR_VALID, 1);     chk("z_pc", oIR_PC, 32'hA);
    chk("z_req", oFETCH_REQ, 1);    chk("z_addr", oFETCH_ADDR, 32'hC);

    // consume and append in the same cycle with count=1
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'h6789_4235; iIR_READY = 1'b1; #1;
    chk("ca_ir", oIR, 32'h0);       chk("ca_pc", oIR_PC, 32'hA);
    step(); iFETCH_VALID = 1'b0; #1;
    chk("ca1_ir", oIR, 32'h4235);   chk("ca1_pc", oIR_PC, 32'hC);
    step(); iIR_READY = 1'b0; #1;
    chk("ca2_ir", oIR, 32'h6789);   chk("ca2_pc", oIR_PC, 32'hE);
    chk("ca2_req", oFETCH_REQ, 1);  chk("ca2_addr", oFETCH_ADDR, 32'h10);

    // flush while a fetch is outstanding
    step(); iFLUSH = 1'b1; iFLUSH_PC = 32'h0000_0102; #1;
    chk("fl_irv", oIR_VALID, 0);    chk("fl_req", oFETCH_REQ, 0);
    step(); iFLUSH = 1'b0; #1;
    chk("drop_req", oFETCH_REQ, 0); chk("drop_irv", oIR_VALID, 0);
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'hDEAD_BEEF; #1;
    chk("stale_req", oFETCH_REQ, 0);
    step(); iFETCH_VALID = 1'b0; #1;
    chk("fl2_req", oFETCH_REQ, 1);  chk("fl2_addr", oFETCH_ADDR, 32'h100);
    chk("fl2_irv", oIR_VALID, 0);
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'h4505_1234; #1;
    step(); iFETCH_VALID = 1'b0; #1;
    chk("fl3_irv", oIR_VALID, 1);   chk("fl3_ir", oIR, 32'h4505);
    chk("fl3_pc", oIR_PC, 32'h102); chk("fl3_req", oFETCH_REQ, 1);
    chk("fl3_addr", oFETCH_ADDR, 32'h104);

    // reset while waiting; a late response is ignored
    step(); iRSTN = 1'b0; #1;
    chk("r2_req", oFETCH_REQ, 0);   chk("r2_irv", oIR_VALID, 0);
    chk("r2_addr", oFETCH_ADDR, 0); chk("r2_pc", oIR_PC, 0);
    chk("r2_ir", oIR, 0);
    step(); iRSTN = 1'b1; iFETCH_VALID = 1'b1; iFETCH_DATA = 32'hFFFF_FFFF; #1;
    chk("r2_req1", oFETCH_REQ, 1);  chk("r2_addr1", oFETCH_ADDR, 0);
    step(); iFETCH_VALID = 1'b0; #1;
    chk("late_irv", oIR_VALID, 0);  chk("late_req", oFETCH_REQ, 0);
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'h4501_4505; #1;
    step(); iFETCH_VALID = 1'b0; #1;
    chk("r2_ir1", oIR, 32'h4505);   chk("r2_pc1", oIR_PC, 0);
    chk("r2_irv1", oIR_VALID, 1);

    // wraparound of fetch address and PC
    step(); iFLUSH = 1'b1; iFLUSH_PC = 32'hFFFF_FFFE; #1;
    step(); iFLUSH = 1'b0; #1;
    chk("w_req", oFETCH_REQ, 1);    chk("w_addr", oFETCH_ADDR, 32'hFFFF_FFFC);
    chk("w_pc", oIR_PC, 32'hFFFF_FFFE); chk("w_irv", oIR_VALID, 0);
    step(); iFETCH_VALID = 1'b1; iFETCH_DATA = 32'h0001_0000; #1;
    step(); iFETCH_VALID = 1'b0; iIR_READY = 1'b1; #1;
    chk("w_ir", oIR, 32'h1);        chk("w_isc", oIR_IS_C, 1);
    chk("w_pc1", oIR_PC, 32'hFFFF_FFFE);
    chk("w_req1", oFETCH_REQ, 1);   chk("w_addr1", oFETCH_ADDR, 32'h0);
    step(); iIR_READY = 1'b0; #1;
    chk("w_pc2", oIR_PC, 32'h0);    chk("w_irv2", oIR_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
